// File: rtl/video_out_hscaler.sv
// Horizontal scaler: captures VDP pixels into banked line buffers and replays the
// previous line through a phase-accumulator resampler (nearest or linear).
module video_out_hscaler #(
    parameter int unsigned IW        = 6,
    parameter int unsigned OW        = 8,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned BANK_BITS = 1,
    parameter int unsigned WR_START  = 0,
    parameter int unsigned OUT_START = 64,
    parameter int unsigned OUT_WIDTH = 1280
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [10:0]          vdp_hcounter,
    input  logic [BANK_BITS-1:0] vdp_vcounter,
    input  logic [10:0]          h_cnt,
    input  logic [IW-1:0]        vdp_r,
    input  logic [IW-1:0]        vdp_g,
    input  logic [IW-1:0]        vdp_b,
    input  logic [7:0]           reg_left_offset,
    input  logic [7:0]           reg_numerator,
    input  logic [7:0]           reg_denominator,
    input  logic [7:0]           reg_normalize,
    input  logic                 reg_mode,
    output logic [OW-1:0]        video_r,
    output logic [OW-1:0]        video_g,
    output logic [OW-1:0]        video_b,
    output logic                 video_de
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned XW    = (AW > 8) ? AW : 8;
    localparam int unsigned BANKS = 1 << BANK_BITS;
    localparam int unsigned PW    = 3 * IW;
    localparam int unsigned MW    = OW + 9;
    localparam int unsigned REP   = (OW + IW - 1) / IW;
    localparam int unsigned RW    = REP * IW;

    localparam logic [10:0] H_LOAD  = 11'(OUT_START - 1);
    localparam logic [10:0] H_FIRST = 11'(OUT_START);
    localparam logic [10:0] H_LAST  = 11'(OUT_START + OUT_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // Widen a source component by repeating its MSBs into the low bits.
    function automatic logic [OW-1:0] expand(input logic [IW-1:0] v);
        logic [RW-1:0] rep;
        rep = {REP{v}};
        return rep[RW-1 -: OW];
    endfunction

    function automatic logic [OW-1:0] mix(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic [7:0] w, input logic lin);
        logic [MW-1:0] acc;
        acc = MW'(a) * MW'(9'd256 - 9'(w)) + MW'(b) * MW'(w);
        return lin ? OW'(acc >> 8) : a;
    endfunction

    // ---------------- write side ----------------
    logic [11:0]               wr_rel;
    logic                      wr_en;
    logic [BANK_BITS+AW-1:0]   wr_addr;
    logic [PW-1:0]             line_mem [BANKS*DEPTH];

    assign wr_rel  = {1'b0, vdp_hcounter} - 12'(WR_START);
    assign wr_en   = enable && !wr_rel[11] && !wr_rel[0] && (12'(wr_rel[10:1]) < 12'(DEPTH));
    assign wr_addr = {vdp_vcounter, AW'(wr_rel[10:1])};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_addr] <= {vdp_r, vdp_g, vdp_b};
        end
    end

    // Read the line finished before the one currently being written.
    logic [BANK_BITS-1:0] rd_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank <= '0;
        end else if (h_cnt == 11'd0) begin
            rd_bank <= BANK_BITS'(vdp_vcounter - BANK_BITS'(1));
        end
    end

    // ---------------- line control ----------------
    state_t state, state_nxt;
    logic   load_line;
    logic   active;
    logic   in_window;

    assign load_line = (h_cnt == H_LOAD);
    assign in_window = (h_cnt >= H_FIRST) && (h_cnt <= H_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        active    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_line) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                active = in_window;
                if (h_cnt == H_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- phase accumulator ----------------
    logic [7:0]    den_eff;
    logic [7:0]    num_eff;
    logic [XW-1:0] src_load;
    logic [7:0]    lat_num;
    logic [7:0]    lat_den;
    logic [7:0]    lat_norm;
    logic          lat_mode;
    logic [7:0]    phase;
    logic [XW-1:0] src_x;
    logic [8:0]    phase_sum;
    logic          phase_wrap;
    logic [7:0]    phase_nxt;
    logic [XW-1:0] src_nxt;
    logic [XW-1:0] src_nbr;
    logic          src_at_end;

    assign den_eff = (reg_denominator == 8'd0) ? 8'd1 : reg_denominator;
    assign num_eff = (reg_numerator < den_eff) ? reg_numerator : den_eff;

    if (DEPTH >= 256) begin : g_offset_fits
        assign src_load = XW'(reg_left_offset);
    end else begin : g_offset_clamp
        assign src_load = (reg_left_offset > 8'(DEPTH - 1)) ? XW'(DEPTH - 1) : XW'(reg_left_offset);
    end

    always_comb begin
        src_at_end = (src_x >= XW'(DEPTH - 1));
        phase_sum  = 9'(phase) + 9'(lat_num);
        phase_wrap = (phase_sum >= {1'b0, lat_den});
        phase_nxt  = phase_wrap ? 8'(phase_sum - {1'b0, lat_den}) : 8'(phase_sum);
        src_nxt    = src_x;
        src_nbr    = src_at_end ? src_x : src_x + XW'(1);
        if (phase_wrap && !src_at_end) begin
            src_nxt = src_x + XW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            src_x    <= '0;
            lat_num  <= '0;
            lat_den  <= 8'd1;
            lat_norm <= '0;
            lat_mode <= 1'b0;
        end else if (load_line) begin
            phase    <= '0;
            src_x    <= src_load;
            lat_num  <= num_eff;
            lat_den  <= den_eff;
            lat_norm <= reg_normalize;
            lat_mode <= reg_mode;
        end else if (active) begin
            phase    <= phase_nxt;
            src_x    <= src_nxt;
        end
    end

    // ---------------- replay pipeline ----------------
    logic          s1_de, s2_de, s3_de;
    logic [AW-1:0] s1_addr_a, s1_addr_b;
    logic [7:0]    s1_phase;
    logic [PW-1:0] s2_pa, s2_pb;
    logic [7:0]    s2_w;
    logic [OW-1:0] s3_r, s3_g, s3_b;
    logic [15:0]   w_prod;
    logic [15:0]   w_shift;
    logic [7:0]    w_sat;

    assign w_prod  = 16'(s1_phase) * 16'(lat_norm);
    assign w_shift = w_prod >> 7;
    assign w_sat   = (w_shift > 16'd255) ? 8'hFF : 8'(w_shift);

    // Datapath registers carry no reset; validity travels with the de chain.
    always_ff @(posedge clk) begin
        s1_addr_a <= AW'(src_x);
        s1_addr_b <= AW'(src_nbr);
        s1_phase  <= phase;
        s2_pa     <= line_mem[{rd_bank, s1_addr_a}];
        s2_pb     <= line_mem[{rd_bank, s1_addr_b}];
        s2_w      <= w_sat;
        s3_r      <= mix(expand(s2_pa[PW-1 -: IW]), expand(s2_pb[PW-1 -: IW]), s2_w, lat_mode);
        s3_g      <= mix(expand(s2_pa[2*IW-1 -: IW]), expand(s2_pb[2*IW-1 -: IW]), s2_w, lat_mode);
        s3_b      <= mix(expand(s2_pa[IW-1:0]), expand(s2_pb[IW-1:0]), s2_w, lat_mode);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_de    <= 1'b0;
            s2_de    <= 1'b0;
            s3_de    <= 1'b0;
            video_de <= 1'b0;
            video_r  <= '0;
            video_g  <= '0;
            video_b  <= '0;
        end else begin
            s1_de    <= active;
            s2_de    <= s1_de;
            s3_de    <= s2_de;
            video_de <= s3_de;
            video_r  <= s3_de ? s3_r : '0;
            video_g  <= s3_de ? s3_g : '0;
            video_b  <= s3_de ? s3_b : '0;
        end
    end

endmodule
